// File: rtl/star_extent_mapper.sv
// star_extent_mapper: walks the frame RAM outward from a seed pixel to find a star's bounding box.
// Each probe is two cycles: *_A presents the address, *_C evaluates the synchronous-read pixel.
module star_extent_mapper #(
  parameter int XSZ       = 3,
  parameter int YSZ       = 3,
  parameter int ADDRSZ    = 6,
  parameter int COLSZ     = 3,
  parameter int MAX_X     = 6,
  parameter int MAX_Y     = 6,
  parameter int THRESHOLD = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              goMapRows,
  input  logic              goMapColumns,
  input  logic [XSZ-1:0]    seedX,
  input  logic [YSZ-1:0]    seedY,
  input  logic [COLSZ-1:0]  pixVal,
  output logic [ADDRSZ-1:0] rdAddr,
  output logic              topBottomFound,
  output logic              leftFound,
  output logic              rightFound,
  output logic [YSZ-1:0]    top,
  output logic [YSZ-1:0]    bottom,
  output logic [XSZ-1:0]    left,
  output logic [XSZ-1:0]    right,
  output logic              busy
);
  typedef enum logic [3:0] {IDLE, UP_A, UP_C, DN_A, DN_C, LT_A, LT_C, RT_A, RT_C} state_t;
  localparam logic [XSZ-1:0] X_LAST = XSZ'(MAX_X - 1);
  localparam logic [YSZ-1:0] Y_LAST = YSZ'(MAX_Y - 1);
  localparam logic [XSZ-1:0] X_ONE  = XSZ'(1);
  localparam logic [YSZ-1:0] Y_ONE  = YSZ'(1);
  state_t state, n_state;
  logic [XSZ-1:0] seed_x, n_sx, n_left, n_right, px;
  logic [YSZ-1:0] mid_y, n_mid, n_top, n_bottom, py;
  logic [YSZ:0] sum;
  logic [ADDRSZ-1:0] addr;
  logic n_tb, n_lf, n_rf, lit, lt_done;
  assign lit = pixVal > COLSZ'(THRESHOLD);
  assign sum = {1'b0, top} + {1'b0, bottom};
  assign busy = state != IDLE;
  always_comb begin
    n_state = state;
    n_top = top;
    n_bottom = bottom;
    n_left = left;
    n_right = right;
    n_sx = seed_x;
    n_mid = mid_y;
    n_tb = topBottomFound;
    n_lf = leftFound;
    n_rf = rightFound;
    lt_done = 1'b0;
    case (state)
      IDLE:
        if (goMapRows) begin
          n_sx = seedX;
          n_top = seedY;
          n_bottom = seedY;
          n_left = seedX;
          n_right = seedX;
          n_lf = 1'b0;
          n_rf = 1'b0;
          n_state = (seedY != '0) ? UP_A : (seedY == Y_LAST) ? IDLE : DN_A;
          n_tb = n_state == IDLE;
        end else if (goMapColumns) begin
          n_mid = sum[YSZ:1];
          n_left = seed_x;
          n_right = seed_x;
          n_lf = seed_x == '0;
          n_state = (seed_x != '0) ? LT_A : (seed_x == X_LAST) ? IDLE : RT_A;
          n_rf = n_state == IDLE;
        end
      UP_A: n_state = UP_C;
      UP_C: begin
        if (lit) n_top = top - Y_ONE;
        n_state = (lit && top - Y_ONE != '0) ? UP_A : (bottom == Y_LAST) ? IDLE : DN_A;
        n_tb = n_state == IDLE;
      end
      DN_A: n_state = DN_C;
      DN_C: begin
        if (lit) n_bottom = bottom + Y_ONE;
        n_state = (lit && bottom + Y_ONE != Y_LAST) ? DN_A : IDLE;
        n_tb = n_state == IDLE;
      end
      LT_A: n_state = LT_C;
      LT_C: begin
        if (lit) n_left = left - X_ONE;
        lt_done = !(lit && left - X_ONE != '0);
        n_lf = lt_done;
        n_state = !lt_done ? LT_A : (right == X_LAST) ? IDLE : RT_A;
        n_rf = n_state == IDLE;
      end
      RT_A: n_state = RT_C;
      RT_C: begin
        if (lit) n_right = right + X_ONE;
        n_state = (lit && right + X_ONE != X_LAST) ? RT_A : IDLE;
        n_rf = n_state == IDLE;
      end
      default: n_state = IDLE;
    endcase
  end
  // probe coordinate is derived from next-cycle values so rdAddr registers together with *_A
  always_comb begin
    px = (n_state == LT_A) ? n_left - X_ONE : (n_state == RT_A) ? n_right + X_ONE : n_sx;
    py = (n_state == UP_A) ? n_top - Y_ONE : (n_state == DN_A) ? n_bottom + Y_ONE : n_mid;
    addr = ADDRSZ'((ADDRSZ+1)'(py) * (ADDRSZ+1)'(MAX_X) + (ADDRSZ+1)'(px));
  end
  always_ff @(posedge clk)
    if (!resetn) begin
      state <= IDLE;
      rdAddr <= '0;
      top <= '0;
      bottom <= '0;
      left <= '0;
      right <= '0;
      seed_x <= '0;
      mid_y <= '0;
      topBottomFound <= 1'b0;
      leftFound <= 1'b0;
      rightFound <= 1'b0;
    end else begin
      state <= n_state;
      if (n_state inside {UP_A, DN_A, LT_A, RT_A}) rdAddr <= addr;
      top <= n_top;
      bottom <= n_bottom;
      left <= n_left;
      right <= n_right;
      seed_x <= n_sx;
      mid_y <= n_mid;
      topBottomFound <= n_tb;
      leftFound <= n_lf;
      rightFound <= n_rf;
    end
endmodule

// File: tb/tb_star_extent_mapper.sv
// tb_star_extent_mapper: directed bench for star_extent_mapper against a 6x6 synchronous-read RAM model.
module tb_star_extent_mapper;
  logic clk = 0, resetn = 0, goMapRows = 0, goMapColumns = 0;
  logic [2:0] seedX = 0, seedY = 0, pixVal = 0;
  logic [5:0] rdAddr;
  logic topBottomFound, leftFound, rightFound, busy;
  logic [2:0] top, bottom, left, right;
  logic [2:0] mem [36];
  int n_chk = 0, n_err = 0, bad_addr = 0, lat_tb, lat_lf, lat_rf;

  star_extent_mapper dut (
    .clk(clk), .resetn(resetn), .goMapRows(goMapRows), .goMapColumns(goMapColumns),
    .seedX(seedX), .seedY(seedY), .pixVal(pixVal), .rdAddr(rdAddr),
    .topBottomFound(topBottomFound), .leftFound(leftFound), .rightFound(rightFound),
    .top(top), .bottom(bottom), .left(left), .right(right), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pixVal <= (rdAddr < 36) ? mem[rdAddr] : 3'd0;
    if (resetn && rdAddr > 35) bad_addr <= bad_addr + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill(input int x0, input int x1, input int y0, input int y1);
    for (int i = 0; i < 36; i++) mem[i] = 3'd0;
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) mem[y*6+x] = 3'd5;
  endtask

  task automatic pulse(input logic r, input logic c, input int sx, input int sy);
    @(negedge clk);
    goMapRows = r;
    goMapColumns = c;
    seedX = 3'(sx);
    seedY = 3'(sy);
    @(posedge clk);
    #1;
    goMapRows = 0;
    goMapColumns = 0;
  endtask

  task automatic measure();
    lat_tb = -1;
    lat_lf = -1;
    lat_rf = -1;
    for (int n = 0; n < 30; n++) begin
      if (topBottomFound && lat_tb < 0) lat_tb = n;
      if (leftFound && lat_lf < 0) lat_lf = n;
      if (rightFound && lat_rf < 0) lat_rf = n;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    fill(2, 3, 1, 3);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", int'({topBottomFound, leftFound, rightFound, busy, top, bottom, left, right, rdAddr}), 0);
    resetn = 1;

    pulse(1, 0, 2, 1);
    measure();
    chk("t1_tb_latency", lat_tb, 8);
    chk("t1_lf_clear", lat_lf, -1);
    chk("t1_top", top, 1);
    chk("t1_bottom", bottom, 3);

    pulse(0, 1, 0, 0);
    measure();
    chk("t2_lf_latency", lat_lf, 2);
    chk("t2_rf_latency", lat_rf, 6);
    chk("t2_left", left, 2);
    chk("t2_right", right, 3);

    fill(0, 0, 0, 0);
    pulse(1, 0, 0, 0);
    measure();
    chk("t3_tb_latency", lat_tb, 2);
    chk("t3_rows", int'({top, bottom}), 0);
    pulse(0, 1, 0, 0);
    measure();
    chk("t3_lf_latency", lat_lf, 0);
    chk("t3_rf_latency", lat_rf, 2);
    chk("t3_cols", int'({left, right}), 0);

    fill(5, 5, 0, 5);
    pulse(1, 0, 5, 5);
    measure();
    chk("t4_tb_latency", lat_tb, 10);
    chk("t4_top", top, 0);
    chk("t4_bottom", bottom, 5);
    pulse(0, 1, 0, 0);
    measure();
    chk("t4_lf_latency", lat_lf, 2);
    chk("t4_rf_latency", lat_rf, 2);
    chk("t4_cols", int'({left, right}), 8'o55);

    fill(2, 3, 1, 3);
    pulse(1, 1, 2, 1);
    measure();
    chk("t5_both_tb_latency", lat_tb, 8);
    chk("t5_both_no_lf", lat_lf, -1);
    chk("t5_both_no_rf", lat_rf, -1);
    pulse(1, 0, 2, 1);
    pulse(0, 1, 0, 0);
    measure();
    chk("t5_busy_flags", int'({topBottomFound, leftFound, rightFound, busy}), 4'b1000);
    chk("t5_busy_rows", int'({top, bottom}), 6'o13);

    pulse(1, 0, 2, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_busy_before_reset", busy, 1);
    resetn = 0;
    @(posedge clk);
    #1;
    chk("t6_reset_outputs", int'({topBottomFound, leftFound, rightFound, busy, top, bottom, left, right, rdAddr}), 0);
    resetn = 1;
    pulse(0, 1, 0, 0);
    measure();
    chk("t6_cols_after_reset_lf", lat_lf, 0);
    chk("t6_cols_after_reset_rf", lat_rf, 2);
    chk("t6_cols_after_reset", int'({left, right}), 0);
    pulse(1, 0, 2, 1);
    measure();
    chk("t6_rerun_tb_latency", lat_tb, 8);
    chk("t6_rerun_rows", int'({top, bottom}), 6'o13);

    chk("addr_range", bad_addr, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
